// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: state encoding and default parameter values for filter_ctrl.
package filter_ctrl_pkg;

  localparam int unsigned NB_INPUT_DEF    = 8;
  localparam int unsigned OV_SAMP_DEF     = 4;
  localparam int unsigned N_FLUSH_SYM_DEF = 6;
  localparam int unsigned NB_CNT_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/filter_ctrl_phase_cnt.sv
// ov_phase_cnt: modulo-OV_SAMP polyphase counter. o_wrap is high on the
// enabled cycle whose edge takes the phase from OV_SAMP-1 back to 0.
module ov_phase_cnt
  import filter_ctrl_pkg::*;
#(
  parameter  int unsigned OV_SAMP = OV_SAMP_DEF,
  localparam int unsigned NB_PH   = $clog2(OV_SAMP)
) (
  input  logic             clk,
  input  logic             i_srst,
  input  logic             i_enb,
  input  logic             i_clr,
  output logic [NB_PH-1:0] o_phase,
  output logic             o_wrap
);

  localparam logic [NB_PH-1:0] LAST = NB_PH'(OV_SAMP - 1);

  logic [NB_PH-1:0] phase_q, phase_d;
  logic             at_last;

  assign at_last = (phase_q == LAST);
  assign o_wrap  = i_enb & ~i_clr & at_last;
  assign o_phase = phase_q;

  // next phase: clear wins, otherwise count modulo OV_SAMP when enabled
  always_comb begin
    phase_d = phase_q;
    if (i_clr) begin
      phase_d = '0;
    end else if (i_enb) begin
      phase_d = at_last ? '0 : phase_q + 1'b1;
    end
  end

  // phase register
  always_ff @(posedge clk) begin
    if (i_srst) phase_q <= '0;
    else        phase_q <= phase_d;
  end

endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl: paces symbols from an upstream source into a polyphase filter
// at one symbol per OV_SAMP clocks, then flushes N_FLUSH_SYM zero symbols.
// Optional macro FILTER_CTRL_STATS_EN adds the o_sym_count statistics port.
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter  int unsigned NB_INPUT    = NB_INPUT_DEF,
  parameter  int unsigned OV_SAMP     = OV_SAMP_DEF,
  parameter  int unsigned N_FLUSH_SYM = N_FLUSH_SYM_DEF,
  parameter  int unsigned NB_CNT      = NB_CNT_DEF,
  localparam int unsigned NB_PH       = $clog2(OV_SAMP)
) (
  input  logic                clk,
  input  logic                i_srst,
  input  logic                i_enb,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_INPUT-1:0] i_sym_data,
  input  logic                i_sym_valid,
  output logic                o_sym_ready,
  output logic [NB_INPUT-1:0] o_is_data,
  output logic                o_valid,
  output logic                o_enb,
  output logic [NB_PH-1:0]    o_phase,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_underrun
`ifdef FILTER_CTRL_STATS_EN
  ,
  output logic [NB_CNT-1:0]   o_sym_count
`endif
);

  localparam int unsigned        FCW       = $clog2(N_FLUSH_SYM + 1);
  localparam logic [FCW-1:0]     FLUSH_END = FCW'(N_FLUSH_SYM - 1);

  if (OV_SAMP < 2 || N_FLUSH_SYM < 1 || NB_CNT < 1) begin : g_param_chk
    $error("filter_ctrl: illegal parameter set");
  end

  state_t                state_q, state_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [NB_INPUT-1:0]   is_data_q, is_data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
`ifdef FILTER_CTRL_STATS_EN
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
`endif

  logic [NB_PH-1:0]      phase;
  logic                  wrap;
  logic                  ph_zero;

  ov_phase_cnt #(
    .OV_SAMP (OV_SAMP)
  ) u_phase (
    .clk     (clk),
    .i_srst  (i_srst),
    .i_enb   (i_enb),
    .i_clr   (state_q == IDLE),
    .o_phase (phase),
    .o_wrap  (wrap)
  );

  assign ph_zero     = (phase == '0);
  assign o_sym_ready = (state_q == RUN) & ph_zero & i_enb;
  assign o_is_data   = is_data_q;
  // Pulses are held while frozen and only shown with i_enb, so a strobe
  // registered just before a freeze is delivered once the block resumes.
  assign o_valid     = valid_q & i_enb;
  assign o_done      = done_q & i_enb;
  assign o_busy      = (state_q != IDLE);
  assign o_enb       = o_busy & i_enb;
  assign o_phase     = phase;
  assign o_underrun  = underrun_q;
`ifdef FILTER_CTRL_STATS_EN
  assign o_sym_count = cnt_q;
`endif

  // sequencing: symbol issue, stop handling and flush countdown
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    flush_cnt_d = flush_cnt_q;
    is_data_d   = is_data_q;
    valid_d     = valid_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
`ifdef FILTER_CTRL_STATS_EN
    cnt_d       = cnt_q;
`endif
    if (i_enb) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d     = RUN;
            stop_pend_d = 1'b0;
            flush_cnt_d = '0;
            underrun_d  = 1'b0;
`ifdef FILTER_CTRL_STATS_EN
            cnt_d       = '0;
`endif
          end
        end
        RUN: begin
          if (ph_zero) begin
            valid_d = 1'b1;
            if (i_sym_valid) begin
              is_data_d = i_sym_data;
`ifdef FILTER_CTRL_STATS_EN
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
            end else begin
              is_data_d  = '0;
              underrun_d = 1'b1;
            end
          end
          if (i_stop) stop_pend_d = 1'b1;
          if (wrap && (stop_pend_q || i_stop)) begin
            state_d     = FLUSH;
            stop_pend_d = 1'b0;
            flush_cnt_d = '0;
          end
        end
        FLUSH: begin
          if (ph_zero) begin
            valid_d   = 1'b1;
            is_data_d = '0;
          end
          if (wrap) begin
            if (flush_cnt_q == FLUSH_END) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              flush_cnt_d = flush_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (i_srst) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      flush_cnt_q <= '0;
      is_data_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef FILTER_CTRL_STATS_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      flush_cnt_q <= flush_cnt_d;
      is_data_q   <= is_data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
`ifdef FILTER_CTRL_STATS_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: directed bench for filter_ctrl with a cycle model of the
// symbol pacing rules and literal checks on hand-computed values.
module tb_filter_ctrl;

  localparam int unsigned NBI = 8;
  localparam int unsigned OV  = 4;
  localparam int unsigned NF  = 6;
`ifdef FILTER_CTRL_STATS_EN
  localparam int unsigned NBC = 2;
`else
  localparam int unsigned NBC = 16;
`endif

  logic           clk;
  logic           i_srst, i_enb, i_start, i_stop, i_sym_valid;
  logic [NBI-1:0] i_sym_data;
  logic           o_sym_ready, o_valid, o_enb, o_busy, o_done, o_underrun;
  logic [NBI-1:0] o_is_data;
  logic [1:0]     o_phase;
`ifdef FILTER_CTRL_STATS_EN
  logic [NBC-1:0] o_sym_count;
`endif

  filter_ctrl #(
    .NB_INPUT    (NBI),
    .OV_SAMP     (OV),
    .N_FLUSH_SYM (NF),
    .NB_CNT      (NBC)
  ) dut (
    .clk         (clk),
    .i_srst      (i_srst),
    .i_enb       (i_enb),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_sym_data  (i_sym_data),
    .i_sym_valid (i_sym_valid),
    .o_sym_ready (o_sym_ready),
    .o_is_data   (o_is_data),
    .o_valid     (o_valid),
    .o_enb       (o_enb),
    .o_phase     (o_phase),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_underrun  (o_underrun)
`ifdef FILTER_CTRL_STATS_EN
    ,
    .o_sym_count (o_sym_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0=idle 1=run 2=flush; tick counts enabled clocks since start
  bit             chk_on = 1'b0;
  int             m_mode, m_tick, m_ftick;
  bit             m_stop;
  bit             e_valid, e_done, e_under;
  logic [NBI-1:0] e_data;
`ifdef FILTER_CTRL_STATS_EN
  int             e_cnt;
`endif

  always @(posedge clk) begin
    if (i_srst) begin
      m_mode = 0; m_tick = 0; m_ftick = 0; m_stop = 0;
      e_valid = 0; e_done = 0; e_under = 0; e_data = '0;
`ifdef FILTER_CTRL_STATS_EN
      e_cnt = 0;
`endif
      chk_on = 1'b1;
    end else if (i_enb) begin
      e_valid = 0;
      e_done  = 0;
      if (m_mode == 0) begin
        if (i_start) begin
          m_mode = 1; m_tick = 0; m_stop = 0; e_under = 0;
`ifdef FILTER_CTRL_STATS_EN
          e_cnt = 0;
`endif
        end
      end else begin
        if (m_tick % OV == 0) begin
          e_valid = 1;
          e_data  = '0;
          if (m_mode == 1) begin
            if (i_sym_valid) begin
              e_data = i_sym_data;
`ifdef FILTER_CTRL_STATS_EN
              if (e_cnt < (2 ** NBC) - 1) e_cnt++;
`endif
            end else begin
              e_under = 1;
            end
          end
        end
        if (m_mode == 1 && i_stop) m_stop = 1;
        m_tick++;
        if (m_mode == 2) begin
          m_ftick++;
          if (m_ftick == NF * OV) begin
            m_mode = 0; m_tick = 0; e_done = 1;
          end
        end else if (m_tick % OV == 0 && m_stop) begin
          m_mode = 2; m_ftick = 0;
        end
      end
    end
  end

  // per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    #1;
    if (chk_on) begin
      check("m_valid",  o_valid,     e_valid & i_enb);
      check("m_data",   o_is_data,   e_data);
      check("m_done",   o_done,      e_done & i_enb);
      check("m_under",  o_underrun,  e_under);
      check("m_busy",   o_busy,      m_mode != 0);
      check("m_phase",  o_phase,     (m_mode != 0) ? m_tick % OV : 0);
      check("m_ready",  o_sym_ready, (m_mode == 1) && (m_tick % OV == 0) && i_enb);
      check("m_enb",    o_enb,       (m_mode != 0) && i_enb);
`ifdef FILTER_CTRL_STATS_EN
      check("m_cnt",    o_sym_count, e_cnt);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nv, rdy, early;
    i_srst = 1; i_enb = 1; i_start = 0; i_stop = 0; i_sym_valid = 0; i_sym_data = '0;
    cyc(); cyc();
    check("rst_busy",  o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_phase", o_phase, 0);
    check("rst_under", o_underrun, 0);
    i_srst = 0;

    // steady run with symbols 0x10, 0x20, 0x30
    i_start = 1; cyc(); i_start = 0;
    i_sym_valid = 1;
    for (int k = 0; k < 3; k++) begin
      i_sym_data = 8'(16 * (k + 1));
      #1 check("ready_p0", o_sym_ready, 1);
      cyc();
      check("sym_data",  o_is_data, 16 * (k + 1));
      check("sym_valid", o_valid, 1);
      check("sym_ph1",   o_phase, 1);
      cyc();
      check("gap_valid", o_valid, 0);
      check("sym_ph2",   o_phase, 2);
      cyc(); cyc();
    end

    // freeze at phase 0 for 3 cycles
    i_enb = 0;
    #1 check("frz_ready", o_sym_ready, 0);
    repeat (3) begin
      cyc();
      check("frz_phase", o_phase, 0);
      check("frz_data",  o_is_data, 8'h30);
      check("frz_valid", o_valid, 0);
      check("frz_busy",  o_busy, 1);
    end
    i_enb = 1;
    i_sym_data = 8'h40;
    #1 check("resume_ready", o_sym_ready, 1);
    cyc();
    check("resume_data", o_is_data, 8'h40);
    repeat (3) cyc();

    // starvation at one phase-0 slot
    i_sym_valid = 0;
    cyc();
    check("starve_data",  o_is_data, 0);
    check("starve_valid", o_valid, 1);
    check("starve_under", o_underrun, 1);
    i_sym_valid = 1; i_sym_data = 8'h50;
    repeat (3) cyc();
    cyc();
    check("after_starve", o_is_data, 8'h50);
    cyc();

    // stop at phase 2: period completes, then 6 zero symbols
    check("stop_ph", o_phase, 2);
    i_stop = 1; cyc(); i_stop = 0;
    cyc();
    check("flush_busy",   o_busy, 1);
    check("under_sticky", o_underrun, 1);
    nv = 0; rdy = 0; early = 0;
    for (int i = 1; i <= int'(NF * OV); i++) begin
      if (o_sym_ready) rdy++;
      cyc();
      if (o_valid && o_is_data == 0) nv++;
      if (i < int'(NF * OV) && o_done) early++;
    end
    check("flush_syms",  nv, NF);
    check("flush_ready", rdy, 0);
    check("flush_early", early, 0);
    check("done_pulse",  o_done, 1);
    check("busy_fall",   o_busy, 0);
`ifdef FILTER_CTRL_STATS_EN
    check("cnt_sat", o_sym_count, 3);
`endif
    cyc();
    check("done_1cyc", o_done, 0);

    // stop ignored in idle
    i_stop = 1; cyc(); i_stop = 0;
    check("idle_stop", o_busy, 0);

    // second run: underrun and count cleared, stop coinciding with phase 0
    i_start = 1; cyc(); i_start = 0;
    check("under_clr", o_underrun, 0);
`ifdef FILTER_CTRL_STATS_EN
    check("cnt_clr", o_sym_count, 0);
`endif
    i_sym_data = 8'h55; i_stop = 1;
    #1 check("stop_p0_ready", o_sym_ready, 1);
    cyc(); i_stop = 0;
    check("stop_p0_data",  o_is_data, 8'h55);
    check("stop_p0_valid", o_valid, 1);
    repeat (3) cyc();
    #1 check("flush_p0_ready", o_sym_ready, 0);
    check("flush_p0_busy", o_busy, 1);
    repeat (NF * OV) cyc();
    check("done2", o_done, 1);

    // third run aborted by reset mid-RUN
    i_start = 1; cyc(); i_start = 0;
    i_sym_data = 8'h66;
    repeat (6) cyc();
    i_srst = 1; cyc(); i_srst = 0;
    check("abort_busy",  o_busy, 0);
    check("abort_data",  o_is_data, 0);
    check("abort_valid", o_valid, 0);
    check("abort_phase", o_phase, 0);
    check("abort_done",  o_done, 0);
    early = 0;
    repeat (30) begin
      cyc();
      if (o_done) early++;
    end
    check("abort_nodone", early, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
- REQ-001 The block SHALL have parameter NB_INPUT, default 8, giving the symbol width in bits.
- REQ-002 The block SHALL have parameter OV_SAMP, default 4, giving clocks per symbol period, with OV_SAMP >= 2.
- REQ-003 The block SHALL have parameter N_FLUSH_SYM, default 6, giving the zero symbols issued after stop, with N_FLUSH_SYM >= 1.
- REQ-004 The block SHALL have parameter NB_CNT, default 16, giving the statistics counter width.
- REQ-005 The block SHALL have the following ports:
  - clk  in  1  single clock, rising edge; runs at T/OV_SAMP.
  - i_srst  in  1  reset; synchronous, active-high.
  - i_enb  in  1  global enable; low freezes the block.
  - i_start  in  1  start request, level-sampled.
  - i_stop  in  1  stop request, level-sampled.
  - i_sym_data  in  NB_INPUT  upstream symbol.
  - i_sym_valid  in  1  upstream symbol available.
  - o_sym_ready  out  1  symbol accepted this cycle when i_sym_valid is also high.
  - o_is_data  out  NB_INPUT  sample to the filter's i_is_data.
  - o_valid  out  1  one-cycle symbol strobe to the filter's i_valid.
  - o_enb  out  1  enable to the filter's i_enb.
  - o_phase  out  $clog2(OV_SAMP)  current polyphase index.
  - o_busy  out  1  high in RUN or FLUSH.
  - o_done  out  1  one-cycle pulse at the end of FLUSH.
  - o_underrun  out  1  sticky symbol-starvation flag.

Function
- REQ-006 The FSM SHALL have exactly the states IDLE, RUN and FLUSH.
- REQ-007 IDLE -> RUN SHALL occur on a cycle with i_start=1 and i_enb=1; phase SHALL load 0 on the same edge.
- REQ-008 In RUN and FLUSH, phase SHALL increment modulo OV_SAMP on every cycle with i_enb=1; OV_SAMP-1 SHALL wrap to 0.
- REQ-009 o_sym_ready SHALL be high only in RUN with phase==0 and i_enb=1; it SHALL be combinational from state and phase, with no dependency on i_sym_valid.
- REQ-010 At RUN phase==0, if i_sym_valid=1, o_is_data SHALL take i_sym_data on the next edge and o_valid SHALL pulse for exactly one cycle (latency 1).
- REQ-011 At RUN phase==0, if i_sym_valid=0, o_is_data SHALL take 0, o_valid SHALL still pulse, and o_underrun SHALL set.
- REQ-012 o_underrun SHALL clear only on reset or on the IDLE -> RUN transition.
- REQ-013 i_stop=1 in RUN SHALL set a pending-stop flag; the RUN -> FLUSH transition SHALL occur at the next phase wrap, and the symbol in flight SHALL complete.
- REQ-014 If i_stop=1 coincides with a RUN phase==0 cycle, that symbol SHALL still be accepted, and FLUSH SHALL begin at the following wrap.
- REQ-015 FLUSH SHALL issue N_FLUSH_SYM zero symbols, each with an o_valid pulse at phase==0, with o_sym_ready=0 throughout.
- REQ-016 After the last flush symbol period completes, the block SHALL go to IDLE and pulse o_done for one cycle.
- REQ-017 i_start SHALL be ignored outside IDLE; i_stop SHALL be ignored in IDLE and in FLUSH.
- REQ-018 o_enb SHALL equal i_enb while o_busy=1, and SHALL be 0 in IDLE.
- REQ-019 While i_enb=0, state, phase and all counters SHALL hold, and o_valid, o_sym_ready and o_done SHALL be 0.
- REQ-020 o_phase SHALL present the registered phase; it SHALL be 0 in IDLE.

Reset
- REQ-021 On i_srst=1 at a clk edge, the block SHALL enter IDLE, with phase, flush counter, pending-stop, o_is_data, o_valid, o_done, o_underrun and o_busy all 0; i_srst SHALL have priority over i_enb.
- REQ-022 Reset asserted during RUN or FLUSH SHALL abort the operation with no o_done pulse.

Configuration
- REQ-023 With macro FILTER_CTRL_STATS_EN defined, the block SHALL add output o_sym_count (out, NB_CNT).
  - o_sym_count SHALL count symbols accepted upstream (REQ-010 cases only).
  - It SHALL saturate at all-ones, clear on reset and on IDLE -> RUN.
- REQ-024 Without FILTER_CTRL_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-025 Package filter_ctrl_pkg SHALL hold the state encoding typedef (IDLE=0, RUN=1, FLUSH=2) and the default parameter constants.
- REQ-026 The modulo-OV_SAMP phase counter with wrap output SHALL be sub-module ov_phase_cnt (inputs clk, i_srst, i_enb, i_clr; outputs o_phase, o_wrap).

Verification
- REQ-027 The bench SHALL cover the following directed scenarios:
  - Reset mid-RUN: i_srst for 1 cycle -> next cycle all outputs 0, state IDLE, no o_done.
  - Steady run: start, always-valid symbols 0x10,0x20,0x30 -> o_valid every 4 clk; o_is_data 0x10,0x20,0x30 one cycle after each ready; o_phase 0,1,2,3 repeating.
  - Starvation: i_sym_valid=0 at one phase-0 slot -> o_is_data=0 with o_valid pulse, o_underrun=1 until next start.
  - Stop: i_stop at phase 2 -> current period completes; 6 zero symbols (24 clk); o_done pulse; o_busy falls; o_sym_ready never high in FLUSH.
  - Freeze: i_enb=0 for 3 cycles mid-RUN -> phase, state and o_is_data hold; o_valid=0; period resumes with no lost symbol.
  - Stats (FILTER_CTRL_STATS_EN, NB_CNT=2): 5 accepted symbols -> o_sym_count=3 (saturated); cleared on next start.
